data_memory_ctrl: RTL and testbench

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

---
 rtl/data_memory_ctrl.sv | 143 ++++++++++++++
 tb/tb_data_memory_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Word-organised data RAM controller: zero-fills memory after reset, then serves byte/half/word
// loads and stores with a fixed READ_LATENCY response pipeline. DMEM_MISALIGN_TRAP_EN faults misaligned accesses.
module data_memory_ctrl #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LastWord = AW'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {StInit, StReady} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          req_ready_q, req_ready_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accept, addr_err, size_err, misalign, req_err, do_write;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data, rd_word, rd_byte, load_data, data_d;
  logic [15:0]   rd_half;
  logic          err_d;

  logic [READ_LATENCY-1:0] vld_q, err_q;
  logic [31:0]             data_q [READ_LATENCY];

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    req_ready_d = req_ready_q;
    unique case (state_q)
      StInit: begin
        init_cnt_d = init_cnt_q + AW'(1);
        if (init_cnt_q == LastWord) begin
          state_d     = StReady;
          req_ready_d = 1'b1;
          init_cnt_d  = '0;
        end
      end
      StReady: req_ready_d = 1'b1;
      default: state_d = StInit;
    endcase
  end

  assign accept   = req_valid & req_ready_q;
  assign word_idx = req_addr[AW+1:2];
  assign addr_err = |req_addr[31:AW+2];
  assign size_err = (req_size == 2'b11);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) |
                    ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign req_err  = addr_err | size_err | misalign;
  assign do_write = accept & req_write & ~req_err;

  // Lane selection ignores the low address bits a halfword/word cannot use (force-align).
  always_comb begin
    lane_en   = '0;
    lane_data = '0;
    load_data = '0;
    rd_word   = mem[word_idx];
    rd_byte   = rd_word >> {req_addr[1:0], 3'b000};
    rd_half   = req_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      2'b00: begin
        lane_en   = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
        load_data = {{24{~req_unsigned & rd_byte[7]}}, rd_byte[7:0]};
      end
      2'b01: begin
        lane_en   = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
        load_data = {{16{~req_unsigned & rd_half[15]}}, rd_half};
      end
      2'b10: begin
        lane_en   = 4'b1111;
        lane_data = req_wdata;
        load_data = rd_word;
      end
      default: ;
    endcase
  end

  assign err_d  = accept & req_err;
  assign data_d = (accept & ~req_write & ~req_err) ? load_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      req_ready_q <= 1'b0;
      vld_q       <= '0;
      err_q       <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      req_ready_q <= req_ready_d;
      vld_q[0]    <= accept;
      err_q[0]    <= err_d;
      data_q[0]   <= data_d;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        err_q[i]  <= err_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  // RAM has no reset; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      mem[init_cnt_q] <= '0;
    end else if (do_write) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lane_en[b]) mem[word_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = vld_q[READ_LATENCY-1];
  assign rsp_rdata = data_q[READ_LATENCY-1];
  assign rsp_err   = err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomised and directed bench for data_memory_ctrl: a 1024-word, latency-3 instance checked
// against a byte-level memory model, plus a 16-word, latency-1 instance for init timing.
module tb_data_memory_ctrl;

  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LAT     = 3;
  localparam int unsigned S_DEPTH = 16;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned, rsp_valid, rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic        s_req_valid, s_req_ready, s_req_write, s_req_unsigned, s_rsp_valid, s_rsp_err;
  logic [1:0]  s_req_size;
  logic [31:0] s_req_addr, s_req_wdata, s_rsp_rdata;

  data_memory_ctrl #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_memory_ctrl #(.DEPTH_WORDS(S_DEPTH), .READ_LATENCY(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_write(s_req_write), .req_size(s_req_size), .req_unsigned(s_req_unsigned),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata), .rsp_valid(s_rsp_valid),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err)
  );

  logic [31:0] cyc = '0;
  rsp_t        got_q[$], exp_q[$], s_got_q[$];
  logic [31:0] model [DEPTH];
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 32'd1;

  always @(negedge clk) begin
    if (rsp_valid)   got_q.push_back('{cyc, rsp_rdata, rsp_err});
    if (s_rsp_valid) s_got_q.push_back('{cyc, s_rsp_rdata, s_rsp_err});
  end

  // Reference: memory as a byte-addressable array; expected response stamped LAT cycles out.
  task automatic send(input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    rsp_t        e;
    logic        err;
    int unsigned w, off, nb;
    logic [31:0] v;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    err = (addr >= DEPTH * 4) || (sz == 2'd3);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0)) err = 1'b1;
`endif
    w   = (addr / 4) % DEPTH;
    off = addr % 4;
    nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (nb == 2) off = (off / 2) * 2;
    if (nb == 4) off = 0;
    v = '0;
    if (!err && wr) begin
      for (int b = 0; b < int'(nb); b++) model[w][8*(off+b) +: 8] = wd[8*b +: 8];
    end else if (!err) begin
      for (int b = 0; b < int'(nb); b++) v[8*b +: 8] = model[w][8*(off+b) +: 8];
      if (!uns && nb < 4 && v[8*nb-1]) begin
        for (int b = int'(nb); b < 4; b++) v[8*b +: 8] = 8'hFF;
      end
    end
    e.cyc = cyc + LAT; e.data = v; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned lat, s_lat;
    logic        s_drop;
    logic [31:0] c0;
    rsp_t        e;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b/%b/%h/%b, expected all zero",
               req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    n_cmp++;
    if ({s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_small: got %b/%b/%h/%b, expected all zero",
               s_req_ready, s_rsp_valid, s_rsp_rdata, s_rsp_err);
    end
    rst_n = 1'b1;
    lat = 0; s_lat = 0; s_drop = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      if (s_lat == 0 && s_req_ready) s_lat = i;
      else if (s_lat != 0 && !s_req_ready) s_drop = 1'b1;
      if (lat == 0 && req_ready) lat = i;
      if (lat != 0) break;
    end
    n_cmp++;
    if (s_lat != S_DEPTH) begin
      n_fail++; $display("FAIL init_cycles_small: got %0d, expected %0d", s_lat, S_DEPTH);
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_fail++; $display("FAIL init_cycles: got %0d, expected %0d", lat, DEPTH);
    end
    n_cmp++;
    if (s_drop !== 1'b0) begin
      n_fail++; $display("FAIL ready_hold_small: req_ready dropped after init, expected held 1");
    end
    @(negedge clk);
    c0 = cyc;
    s_req_valid = 1'b1; s_req_write = 1'b0; s_req_size = 2'b10; s_req_unsigned = 1'b0;
    s_req_addr = 32'h0000_003C;
    @(negedge clk);
    s_req_addr = 32'h0000_0040;
    @(negedge clk);
    s_req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (s_got_q.size() != 2) begin
      n_fail++; $display("FAIL small_count: got %0d responses, expected 2", s_got_q.size());
    end else begin
      e.cyc = c0 + 32'd1; e.data = '0; e.err = 1'b0;
      n_cmp++;
      if (s_got_q[0] !== e) begin
        n_fail++; $display("FAIL small_load_3c: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           s_got_q[0].cyc, s_got_q[0].data, s_got_q[0].err, e.cyc, e.data, e.err);
      end
      e.cyc = c0 + 32'd2; e.err = 1'b1;
      n_cmp++;
      if (s_got_q[1] !== e) begin
        n_fail++; $display("FAIL small_oor_40: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           s_got_q[1].cyc, s_got_q[1].data, s_got_q[1].err, e.cyc, e.data, e.err);
      end
    end
    s_got_q.delete();
  endtask

  task automatic test_lanes();
    logic [31:0] lit [5] = '{32'h0, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF};
    send(1'b1, 2'd2, 1'b0, 32'h100, 32'h80FF_7F01);
    send(1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
    send(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    send(1'b0, 2'd1, 1'b0, 32'h100, 32'h0);
    send(1'b0, 2'd1, 1'b1, 32'h102, 32'h0);
    idle(); repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL lanes_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || got_q[i].data !== lit[i]) begin
        n_fail++; $display("FAIL lanes_rsp[%0d]: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           i, got_q[i].cyc, got_q[i].data, got_q[i].err,
                           exp_q[i].cyc, lit[i], exp_q[i].err);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back();
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
    send(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    send(1'b0, 2'd2, 1'b1, 32'h100, 32'h0);
    send(1'b0, 2'd1, 1'b0, 32'h102, 32'h0);
    send(1'b0, 2'd0, 1'b1, 32'h101, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    idle(); repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_rsp[%0d]: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           i, got_q[i].cyc, got_q[i].data, got_q[i].err,
                           exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    if (got_q.size() > 2) begin
      n_cmp++;
      if (got_q[2].data !== 32'h1122_AA44) begin
        n_fail++; $display("FAIL b2b_merge: got %h, expected 1122aa44", got_q[2].data);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_misalign_range();
    rsp_t e;
`ifdef DMEM_MISALIGN_TRAP_EN
    e.data = 32'h0;         e.err = 1'b1;
`else
    e.data = 32'h80FF_7F01; e.err = 1'b0;
`endif
    send(1'b0, 2'd2, 1'b0, 32'h102, 32'h0);
    send(1'b1, 2'd2, 1'b0, 32'h1000, 32'hDEAD_BEEF);
    send(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    send(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFF_FFFF);
    send(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
    send(1'b0, 2'd3, 1'b0, 32'h100, 32'h0);
    send(1'b1, 2'd1, 1'b0, 32'h101, 32'h0000_5A5A);
    send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    idle(); repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL misalign_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL misalign_rsp[%0d]: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           i, got_q[i].cyc, got_q[i].data, got_q[i].err,
                           exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    if (got_q.size() > 2) begin
      n_cmp++;
      if (got_q[0].data !== e.data || got_q[0].err !== e.err) begin
        n_fail++; $display("FAIL lw_102: got data %h err %b, expected data %h err %b",
                           got_q[0].data, got_q[0].err, e.data, e.err);
      end
      n_cmp++;
      if (got_q[2].err !== 1'b1) begin
        n_fail++; $display("FAIL lw_1000_err: got %b, expected 1", got_q[2].err);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [1:0]  sz;
    logic [31:0] addr;
    int unsigned r;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else begin
        sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        r  = $urandom_range(0, 19);
        if (r == 0)      addr = (32'h1000 << $urandom_range(0, 19)) | $urandom_range(0, 4095);
        else if (r == 1) addr = $urandom_range(0, 4095);
        else             addr = $urandom_range(0, 63);
        send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom);
      end
    end
    idle(); repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL random_rsp[%0d]: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           i, got_q[i].cyc, got_q[i].data, got_q[i].err,
                           exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_inflight();
    int unsigned lat;
    send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    send(1'b0, 2'd1, 1'b1, 32'h10, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_rdata, rsp_err} !== 35'd0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b/%b/%h/%b, expected all zero",
                         req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_fail++; $display("FAIL reinit_cycles: got %0d, expected %0d", lat, DEPTH);
    end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_fail++; $display("FAIL inflight_dropped: got %0d responses, expected 0", got_q.size());
    end
    got_q.delete();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    send(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    send(1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
    send(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0);
    idle(); repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL postreset_count: got %0d, expected %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL postreset_rsp[%0d]: got cyc %0d data %h err %b, expected cyc %0d data %h err %b",
                           i, got_q[i].cyc, got_q[i].data, got_q[i].err,
                           exp_q[i].cyc, exp_q[i].data, exp_q[i].err);
      end
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_write = 1'b0; s_req_size = 2'd0; s_req_unsigned = 1'b0;
    s_req_addr = '0; s_req_wdata = '0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    test_reset();
    test_lanes();
    test_back_to_back();
    test_misalign_range();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
